// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM port status and the machine word.
package cpu_types_pkg;

  // Status reported by the RAM for the access currently on its strobes.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/memory_arbiter.sv
// Arbitrates icache and dcache single-word requests onto one RAM port.
// Data side wins by default; instruction fetch is guaranteed a grant after
// STARVE_MAX consecutive data grants taken while it was waiting.
//
// Handshake: a cache raises its request (iREN, or dREN/dWEN) and holds it,
// with address and data stable, until it sees its wait low for exactly one
// cycle. That low-wait cycle is the completion; load data is valid only then.
// If the cache changes or drops its request before completion, the RAM access
// still finishes but its wait stays high and the result is discarded.
//
// arb_state is a debug view of the FSM: 0 = idle, 1 = data access,
// 2 = instruction access.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  ramstate_t         ramstate,
  output logic [1:0]        arb_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2
  } arb_state_t;

  localparam int                CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_t         state, state_n;
  logic [CNT_W-1:0]   starve_cnt, starve_cnt_n;
  logic [ADDR_W-1:0]  lat_addr, lat_addr_n;
  logic [WORD_W-1:0]  lat_store, lat_store_n;
  logic               lat_dren, lat_dren_n;
  logic               lat_dwen, lat_dwen_n;

  logic d_req;
  logic i_starved;

  assign d_req     = dREN | dWEN;
  assign i_starved = iREN && (starve_cnt == CNT_MAX);

  assign ramaddr   = lat_addr;
  assign ramstore  = lat_store;
  assign arb_state = state;

  // State, starvation counter and the latched request held for the RAM.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_addr   <= '0;
      lat_store  <= '0;
      lat_dren   <= 1'b0;
      lat_dwen   <= 1'b0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_cnt_n;
      lat_addr   <= lat_addr_n;
      lat_store  <= lat_store_n;
      lat_dren   <= lat_dren_n;
      lat_dwen   <= lat_dwen_n;
    end
  end

  // Grant decision in IDLE, RAM strobes and completion signalling in the
  // access states. Completion is only reported while the winner still
  // presents the exact request that was granted.
  always_comb begin
    state_n      = state;
    starve_cnt_n = starve_cnt;
    lat_addr_n   = lat_addr;
    lat_store_n  = lat_store;
    lat_dren_n   = lat_dren;
    lat_dwen_n   = lat_dwen;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    iwait        = 1'b1;
    dwait        = 1'b1;
    iload        = '0;
    dload        = '0;

    case (state)
      IDLE: begin
        if (d_req && !i_starved) begin
          state_n     = D_ACC;
          lat_addr_n  = daddr;
          lat_store_n = dstore;
          lat_dren_n  = dREN;
          lat_dwen_n  = dWEN;
          if (!iREN) begin
            starve_cnt_n = '0;
          end else if (starve_cnt != CNT_MAX) begin
            starve_cnt_n = starve_cnt + CNT_W'(1);
          end
        end else if (iREN) begin
          state_n      = I_ACC;
          lat_addr_n   = iaddr;
          lat_store_n  = '0;
          lat_dren_n   = 1'b0;
          lat_dwen_n   = 1'b0;
          starve_cnt_n = '0;
        end
      end

      D_ACC: begin
        // A write wins over a read when both were requested together.
        ramWEN = lat_dwen;
        ramREN = ~lat_dwen;
        if (ramstate == ACCESS) begin
          state_n = IDLE;
          if ((dREN == lat_dren) && (dWEN == lat_dwen)) begin
            dwait = 1'b0;
            dload = ramload;
          end
        end
      end

      I_ACC: begin
        ramREN = 1'b1;
        if (ramstate == ACCESS) begin
          state_n = IDLE;
          if (iREN) begin
            iwait = 1'b0;
            iload = ramload;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: a behavioural RAM with programmable latency and
// error cycles, a table of single transactions, hand sequences for the
// multi-cycle corners, and a randomized two-requester run against a
// transaction-level arbitration model.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int STARVE_MAX = 4;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- DUT signals ----------------
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic [1:0]  arb_state;
  ramstate_t   rs;

  memory_arbiter #(.WORD_W(32), .ADDR_W(32), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(rs), .arb_state(arb_state)
  );

  // ---------------- behavioural RAM ----------------
  // Each access shows cfg_err ERROR cycles, then cfg_lat-1 BUSY cycles,
  // then one ACCESS cycle. Unwritten words read back base_word(addr).
  int cfg_lat = 1;
  int cfg_err = 0;
  int acc_cyc = 0;
  bit [31:0] mem_d[1024];
  bit        mem_v[1024];

  function automatic logic [31:0] base_word(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return {~a[15:0], a[15:0]};
  endfunction

  always_comb begin
    if (!(ramREN | ramWEN))                rs = FREE;
    else if (acc_cyc < cfg_err)            rs = ERROR;
    else if (acc_cyc < cfg_err + cfg_lat - 1) rs = BUSY;
    else                                   rs = ACCESS;
  end

  always_comb begin
    if (mem_v[ramaddr[11:2]]) ramload = mem_d[ramaddr[11:2]];
    else                      ramload = base_word(ramaddr);
  end

  always @(posedge CLK) begin
    if ((ramREN | ramWEN) && rs == ACCESS && ramWEN) begin
      mem_d[ramaddr[11:2]] <= ramstore;
      mem_v[ramaddr[11:2]] <= 1'b1;
    end
    if (!(ramREN | ramWEN) || rs == ACCESS) acc_cyc <= 0;
    else                                    acc_cyc <= acc_cyc + 1;
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  bit [31:0] ref_d[1024];
  bit        ref_v[1024];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    if (ref_v[a[11:2]]) return ref_d[a[11:2]];
    return base_word(a);
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
    ref_d[a[11:2]] = d;
    ref_v[a[11:2]] = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    drive_idle();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  typedef struct {
    bit          is_d;
    bit          ren;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] store;
    int          lat;
    int          err;
    logic [31:0] exp_load;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[6];

  // One complete transaction from a single requester, checked cycle by cycle.
  task automatic do_vec(input vec_t v, input string tag);
    bit done;
    int k;
    logic w, wo;
    logic [31:0] ld;
    @(posedge CLK); #1;
    cfg_lat = v.lat; cfg_err = v.err;
    if (v.is_d) begin
      dREN = v.ren; dWEN = v.wen; daddr = v.addr; dstore = v.store;
    end else begin
      iREN = 1'b1; iaddr = v.addr;
    end
    @(negedge CLK);
    chk({tag, " idle strobes"}, {30'd0, ramREN, ramWEN}, 32'd0);
    chk({tag, " idle waits"}, {30'd0, iwait, dwait}, 32'd3);
    done = 1'b0;
    k = 0;
    while (!done && k < 40) begin
      @(negedge CLK);
      k++;
      w  = v.is_d ? dwait : iwait;
      wo = v.is_d ? iwait : dwait;
      ld = v.is_d ? dload : iload;
      chk({tag, " strobes"}, {30'd0, ramREN, ramWEN},
          (v.is_d && v.wen) ? 32'd1 : 32'd2);
      chk({tag, " ramaddr"}, ramaddr, v.addr);
      chk({tag, " loser wait"}, {31'd0, wo}, 32'd1);
      if (v.is_d && v.wen) chk({tag, " ramstore"}, ramstore, v.store);
      if (!w) begin
        done = 1'b1;
        chk({tag, " latency"}, k, v.exp_cyc);
        if (!(v.is_d && v.wen)) chk({tag, " load"}, ld, v.exp_load);
      end else begin
        chk({tag, " load idle"}, ld, 32'd0);
      end
    end
    chk({tag, " completed"}, {31'd0, done}, 32'd1);
    @(posedge CLK); #1;
    drive_idle();
    if (v.is_d && v.wen) ref_write(v.addr, v.store);
    @(negedge CLK);
    chk({tag, " back to idle"}, {30'd0, arb_state}, 32'd0);
    chk({tag, " idle waits after"}, {30'd0, iwait, dwait}, 32'd3);
  endtask

  // ---------------- test body ----------------
  initial begin
    bit exp_d[6];
    bit prev_s;
    int g;
    int k;

    vecs[0] = '{0, 1, 0, 32'h040, 32'h0,        1, 0, 32'hDEADBEEF, 1};
    vecs[1] = '{1, 0, 1, 32'h100, 32'h1234,     3, 0, 32'h0,        3};
    vecs[2] = '{1, 1, 0, 32'h100, 32'h0,        1, 0, 32'h00001234, 1};
    vecs[3] = '{1, 0, 1, 32'h804, 32'hCAFEF00D, 2, 0, 32'h0,        2};
    vecs[4] = '{1, 1, 0, 32'h804, 32'h0,        2, 1, 32'hCAFEF00D, 3};
    vecs[5] = '{0, 1, 0, 32'h044, 32'h0,        2, 0, 32'hFFBB0044, 2};

    // Reset values while nRST is held low.
    #12;
    chk("reset strobes", {30'd0, ramREN, ramWEN}, 32'd0);
    chk("reset waits", {30'd0, iwait, dwait}, 32'd3);
    chk("reset loads", iload | dload, 32'd0);
    chk("reset ramaddr", ramaddr, 32'd0);
    chk("reset ramstore", ramstore, 32'd0);
    chk("reset state", {30'd0, arb_state}, 32'd0);
    do_reset();

    // Table of single transactions.
    for (int i = 0; i < 6; i++) do_vec(vecs[i], $sformatf("vec%0d", i));

    // Both requesters held: four data grants, then the starved fetch.
    do_reset();
    cfg_lat = 1; cfg_err = 0;
    exp_d = '{1, 1, 1, 1, 0, 1};
    @(posedge CLK); #1;
    iREN = 1'b1; iaddr = 32'h40; dREN = 1'b1; daddr = 32'h900;
    prev_s = 1'b0; g = 0; k = 0;
    while (g < 6 && k < 60) begin
      @(negedge CLK);
      k++;
      if ((ramREN | ramWEN) && !prev_s) begin
        chk($sformatf("starve grant%0d is data", g), {31'd0, ramaddr == 32'h900},
            {31'd0, exp_d[g]});
        g++;
      end
      if (!iwait) chk("starve iload", iload, 32'hDEADBEEF);
      prev_s = ramREN | ramWEN;
    end
    chk("starve grant count", g, 6);
    drive_idle();

    // ERROR twice, then ACCESS: strobe held, no completion until ACCESS.
    do_reset();
    @(posedge CLK); #1;
    cfg_lat = 1; cfg_err = 2;
    dREN = 1'b1; daddr = 32'h100;
    @(negedge CLK);
    for (int c = 1; c <= 2; c++) begin
      @(negedge CLK);
      chk($sformatf("error c%0d ramREN", c), {31'd0, ramREN}, 32'd1);
      chk($sformatf("error c%0d dwait", c), {31'd0, dwait}, 32'd1);
      chk($sformatf("error c%0d dload", c), dload, 32'd0);
    end
    @(negedge CLK);
    chk("error done dwait", {31'd0, dwait}, 32'd0);
    chk("error done dload", dload, 32'h1234);
    @(posedge CLK); #1;
    drive_idle();

    // Asynchronous reset in the middle of a data access.
    @(posedge CLK); #1;
    cfg_lat = 6; cfg_err = 0;
    dREN = 1'b1; daddr = 32'h804;
    repeat (3) @(negedge CLK);
    chk("pre-reset ramREN", {31'd0, ramREN}, 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("midreset strobes", {30'd0, ramREN, ramWEN}, 32'd0);
    chk("midreset dwait", {31'd0, dwait}, 32'd1);
    chk("midreset ramaddr", ramaddr, 32'd0);
    chk("midreset state", {30'd0, arb_state}, 32'd0);
    drive_idle();
    @(posedge CLK); #1 nRST = 1'b1;
    do_vec(vecs[0], "post-reset fetch");

    // Read+write together: write wins; dropping dREN withdraws the request.
    @(posedge CLK); #1;
    cfg_lat = 3; cfg_err = 0;
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h8; dstore = 32'h5555AAAA;
    @(negedge CLK);
    @(negedge CLK);
    chk("rw strobes", {30'd0, ramREN, ramWEN}, 32'd1);
    @(posedge CLK); #1 dREN = 1'b0;
    @(negedge CLK);
    chk("withdraw c2 dwait", {31'd0, dwait}, 32'd1);
    chk("withdraw c2 ramWEN", {31'd0, ramWEN}, 32'd1);
    @(negedge CLK);
    chk("withdraw ramstate", {30'd0, rs}, {30'd0, ACCESS});
    chk("withdraw access dwait", {31'd0, dwait}, 32'd1);
    @(posedge CLK); #1 dWEN = 1'b0;
    ref_write(32'h8, 32'h5555AAAA);
    @(negedge CLK);
    chk("withdraw idle state", {30'd0, arb_state}, 32'd0);
    chk("withdraw idle dwait", {31'd0, dwait}, 32'd1);

    // Randomized run against the arbitration model.
    do_reset();
    begin
      bit i_pend, d_pend, d_w, new_cfg, prev_i, prev_d, prev_str, str, exp_side_d;
      logic [31:0] i_a, d_a, d_s, cur_a, r;
      int i_age, d_age, consec;
      i_pend = 0; d_pend = 0; d_w = 0; new_cfg = 1; prev_i = 0; prev_d = 0;
      prev_str = 0; i_a = 0; d_a = 0; d_s = 0; cur_a = 0;
      i_age = 0; d_age = 0; consec = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        @(posedge CLK); #1;
        if (new_cfg) begin
          cfg_lat = $urandom_range(1, 3);
          cfg_err = ($urandom_range(0, 3) == 0) ? 1 : 0;
          new_cfg = 0;
        end
        if (!i_pend && $urandom_range(0, 2) == 0) begin
          r = $urandom;
          i_pend = 1; i_age = 0; i_a = {20'h0, 1'b0, r[8:0], 2'b00};
        end
        if (!d_pend && $urandom_range(0, 2) == 0) begin
          r = $urandom;
          d_pend = 1; d_age = 0; d_w = r[31]; d_a = {20'h0, 1'b1, r[8:0], 2'b00};
          d_s = $urandom;
        end
        iREN = i_pend; iaddr = i_a;
        dREN = d_pend & ~d_w; dWEN = d_pend & d_w; daddr = d_a; dstore = d_s;
        @(negedge CLK);
        str = ramREN | ramWEN;
        if (str && !prev_str) begin
          exp_side_d = prev_d && !(prev_i && consec >= STARVE_MAX);
          chk("rand grant side", {31'd0, ramaddr[11]}, {31'd0, exp_side_d});
          if (exp_side_d) consec = prev_i ? ((consec < STARVE_MAX) ? consec + 1 : consec) : 0;
          else            consec = 0;
          cur_a = exp_side_d ? d_a : i_a;
          chk("rand grant addr", ramaddr, cur_a);
          if (exp_side_d && d_w) chk("rand grant store", ramstore, d_s);
          chk("rand grant op", {30'd0, ramREN, ramWEN},
              (exp_side_d && d_w) ? 32'd1 : 32'd2);
        end else if (str) begin
          chk("rand addr stable", ramaddr, cur_a);
        end
        if (!iwait) begin
          chk("rand iwait while pending", {31'd0, i_pend}, 32'd1);
          chk("rand iload", iload, exp_word(i_a));
          i_pend = 0; new_cfg = 1;
        end else if (iload != 32'd0) begin
          chk("rand iload idle", iload, 32'd0);
        end
        if (!dwait) begin
          chk("rand dwait while pending", {31'd0, d_pend}, 32'd1);
          if (d_w) ref_write(d_a, d_s);
          else begin
            exp_q.push_back(exp_word(d_a));
            chk("rand dload", dload, exp_q.pop_front());
          end
          d_pend = 0; new_cfg = 1;
        end else if (dload != 32'd0) begin
          chk("rand dload idle", dload, 32'd0);
        end
        prev_i = iREN; prev_d = dREN | dWEN; prev_str = str;
        if (i_pend) i_age++;
        if (d_pend) d_age++;
        if (i_age > 100) begin chk("rand i timeout", i_age, 100); i_pend = 0; i_age = 0; end
        if (d_age > 100) begin chk("rand d timeout", d_age, 100); d_pend = 0; d_age = 0; end
      end
      drive_idle();
    end

    repeat (3) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
